sequence_generator_serial: RTL and testbench



---
 rtl/seq_gen_pkg.sv | 18 +
 rtl/bit_shifter.sv | 44 ++++
 rtl/sequence_generator_serial.sv | 125 ++++++++++++
 tb/tb_sequence_generator_serial.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/seq_gen_pkg.sv
// seq_gen_pkg: shared types, width helper and test frames for the serial sequence generator.
package seq_gen_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_GAP} state_t;

    function automatic int len_w(input int width);
        return $clog2(width) + 1;
    endfunction

    // Reference frames, right-justified as they are presented on load_data
    localparam logic [15:0] FRAME_1011   = 16'h000B;
    localparam int          FRAME_1011_L = 4;
    localparam logic [15:0] FRAME_110    = 16'h0006;
    localparam int          FRAME_110_L  = 3;
    localparam logic [15:0] FRAME_A5     = 16'h00A5;
    localparam int          FRAME_A5_L   = 8;

endpackage

// File: rtl/bit_shifter.sv
// bit_shifter: WIDTH-bit left-shift register that left-justifies a len-bit frame and replays it on reload.
module bit_shifter #(
    parameter int WIDTH = 16,
    parameter int LEN_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic             reload_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic [LEN_W-1:0] len_i,
    output logic             msb_o
);

    logic [WIDTH-1:0] frame_q, frame_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] just;
    logic [LEN_W-1:0] pad;

    // Shifting by WIDTH-len discards everything above the frame field
    assign pad  = LEN_W'(WIDTH) - len_i;
    assign just = data_i << pad;

    always_comb begin
        frame_d = load_i ? just : frame_q;
        sr_d    = load_i   ? just :
                  reload_i ? frame_q :
                  shift_i  ? {sr_q[WIDTH-2:0], 1'b0} : sr_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_q <= '0;
            sr_q    <= '0;
        end else begin
            frame_q <= frame_d;
            sr_q    <= sr_d;
        end
    end

    assign msb_o = sr_q[WIDTH-1];

endmodule

// File: rtl/sequence_generator_serial.sv
// sequence_generator_serial: shifts a handshaked frame out MSB-first, repeated with an optional idle gap.
module sequence_generator_serial
    import seq_gen_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8,
    parameter int GAP   = 0,
    parameter int LEN_W = len_w(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic [LEN_W-1:0] load_len,
    input  logic [CNT_W-1:0] load_repeat,
    input  logic             abort,
    output logic             out_bit,
    output logic             out_valid,
    output logic             busy,
    output logic             done
);

    localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] bit_q, bit_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] rep_q, rep_d;
    logic [GW-1:0]    gap_q, gap_d;
    logic [LEN_W-1:0] eff_len;
    logic [CNT_W-1:0] eff_rep;
    logic             last_bit, last_rep, final_bit, hs;
    logic             sh_load, sh_shift, sh_reload, msb;

    assign eff_len   = (load_len == '0 || load_len > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : load_len;
    assign eff_rep   = (load_repeat == '0) ? CNT_W'(1) : load_repeat;
    assign last_bit  = bit_q == '0;
    assign last_rep  = rep_q == CNT_W'(1);
    assign final_bit = state_q == ST_SHIFT && last_bit && last_rep;
    assign load_ready = !abort && (state_q == ST_IDLE || final_bit);
    assign hs        = load_valid && load_ready;

    always_comb begin
        state_d   = state_q;
        bit_d     = bit_q;
        len_d     = len_q;
        rep_d     = rep_q;
        gap_d     = gap_q;
        sh_load   = 1'b0;
        sh_shift  = 1'b0;
        sh_reload = 1'b0;
        if (abort) begin
            state_d = ST_IDLE;
        end else if (hs) begin
            sh_load = 1'b1;
            state_d = ST_SHIFT;
            len_d   = eff_len;
            bit_d   = eff_len - LEN_W'(1);
            rep_d   = eff_rep;
        end else if (state_q == ST_SHIFT) begin
            if (!last_bit) begin
                sh_shift = 1'b1;
                bit_d    = bit_q - LEN_W'(1);
            end else if (last_rep) begin
                state_d = ST_IDLE;
            end else begin
                // Frame is restored immediately; during a gap the register just holds it
                sh_reload = 1'b1;
                bit_d     = len_q - LEN_W'(1);
                rep_d     = rep_q - CNT_W'(1);
                state_d   = (GAP > 0) ? ST_GAP : ST_SHIFT;
                gap_d     = GW'(GAP > 0 ? GAP - 1 : 0);
            end
        end else if (state_q == ST_GAP) begin
            state_d = (gap_q == '0) ? ST_SHIFT : ST_GAP;
            gap_d   = (gap_q == '0) ? gap_q : gap_q - GW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            bit_q   <= '0;
            len_q   <= '0;
            rep_q   <= '0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            len_q   <= len_d;
            rep_q   <= rep_d;
        end
    end

    generate
        if (GAP > 0) begin : g_gap
            always_ff @(posedge clk or posedge reset) begin
                if (reset) gap_q <= '0;
                else       gap_q <= gap_d;
            end
        end else begin : g_nogap
            logic unused_gap;
            assign gap_q      = '0;
            assign unused_gap = ^gap_d;
        end
    endgenerate

    bit_shifter #(.WIDTH(WIDTH), .LEN_W(LEN_W)) u_shifter (
        .clk      (clk),
        .reset    (reset),
        .load_i   (sh_load),
        .shift_i  (sh_shift),
        .reload_i (sh_reload),
        .data_i   (load_data),
        .len_i    (eff_len),
        .msb_o    (msb)
    );

    assign out_valid = state_q == ST_SHIFT;
    assign out_bit   = out_valid && msb;
    assign busy      = state_q != ST_IDLE;
    // An abort landing on the final bit cancels the completion pulse
    assign done      = final_bit && !abort;

endmodule

// File: tb/tb_sequence_generator_serial.sv
// tb_sequence_generator_serial: directed checks of a GAP=0 and a GAP=2 generator driven in parallel.
module tb_sequence_generator_serial;
    import seq_gen_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        lv = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] ldata = '0;
    logic [4:0]  llen = '0;
    logic [7:0]  lrep = '0;
    logic        r0, b0, v0, bz0, d0;
    logic        r2, b2, v2, bz2, d2;
    int          tests = 0;
    int          fails = 0;
    int          dc0 = 0;
    int          dc2 = 0;
    int          base0, base2;
    logic [12:0] eb0, ev0, ed0, eb2, ev2, ed2;
    logic [15:0] e16;

    always #5 clk = ~clk;

    sequence_generator_serial #(.WIDTH(16), .CNT_W(8), .GAP(0)) u0 (
        .clk(clk), .reset(reset), .load_valid(lv), .load_ready(r0), .load_data(ldata),
        .load_len(llen), .load_repeat(lrep), .abort(abort), .out_bit(b0),
        .out_valid(v0), .busy(bz0), .done(d0)
    );

    sequence_generator_serial #(.WIDTH(16), .CNT_W(8), .GAP(2)) u2 (
        .clk(clk), .reset(reset), .load_valid(lv), .load_ready(r2), .load_data(ldata),
        .load_len(llen), .load_repeat(lrep), .abort(abort), .out_bit(b2),
        .out_valid(v2), .busy(bz2), .done(d2)
    );

    always @(posedge clk) begin
        if (d0) dc0++;
        if (d2) dc2++;
    end

    task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [15:0] d, input logic [4:0] l, input logic [7:0] r);
        ldata = d;
        llen  = l;
        lrep  = r;
        lv    = 1'b1;
        step();
        lv    = 1'b0;
    endtask

    initial begin
        // Reset: {ready,busy,valid} and {bit,valid,done}
        #1 reset = 1'b1;
        #2;
        chk("rst_status0", {r0, bz0, v0}, 3'b100);
        chk("rst_out0", {b0, v0, d0}, 3'b000);
        chk("rst_status2", {r2, bz2, v2}, 3'b100);
        step();
        step();
        reset = 1'b0;
        step();

        // Single frame 1011
        base0 = dc0;
        load(FRAME_1011, 5'(FRAME_1011_L), 8'd1);
        chk("single_b1", {b0, v0, d0}, 3'b110);
        chk("single_busy", {r0, bz0, v0}, 3'b011);
        step(); chk("single_b2", {b0, v0, d0}, 3'b010);
        step(); chk("single_b3", {b0, v0, d0}, 3'b110);
        step(); chk("single_b4", {b0, v0, d0}, 3'b111);
        step(); chk("single_idle", {r0, bz0, v0}, 3'b100);
        chk("single_done_cnt", 3'(dc0 - base0), 3'd1);

        // Repeat x3: u2 with two gap cycles, u0 back-to-back
        eb2 = 13'b1100011000110; ev2 = 13'b1110011100111; ed2 = 13'b0000000000001;
        eb0 = 13'b1101101100000; ev0 = 13'b1111111110000; ed0 = 13'b0000000010000;
        base0 = dc0;
        base2 = dc2;
        load(FRAME_110, 5'(FRAME_110_L), 8'd3);
        for (int i = 0; i < 13; i++) begin
            chk($sformatf("gap2_c%0d", i + 1), {b2, v2, d2}, {eb2[12-i], ev2[12-i], ed2[12-i]});
            chk($sformatf("gap0_c%0d", i + 1), {b0, v0, d0}, {eb0[12-i], ev0[12-i], ed0[12-i]});
            step();
        end
        chk("gap2_idle", {r2, bz2, v2}, 3'b100);
        chk("gap2_done_cnt", 3'(dc2 - base2), 3'd1);
        chk("gap0_done_cnt", 3'(dc0 - base0), 3'd1);

        // Seamless reload: 101 then 10, second handshake on the final bit
        base0 = dc0;
        load(16'h0005, 5'd3, 8'd1);
        chk("b2b_a1", {b0, v0, d0}, 3'b110);
        step(); chk("b2b_a2", {b0, v0, d0}, 3'b010);
        step(); chk("b2b_a3", {b0, v0, d0}, 3'b111);
        chk("b2b_ready_last", {r0, bz0, v0}, 3'b111);
        load(16'h0002, 5'd2, 8'd1);
        chk("b2b_b1", {b0, v0, d0}, 3'b110);
        step(); chk("b2b_b2", {b0, v0, d0}, 3'b011);
        step(); chk("b2b_idle", {r0, bz0, v0}, 3'b100);
        chk("b2b_done_cnt", 3'(dc0 - base0), 3'd2);

        // Abort on the second bit of 10100101, with a competing load request
        base0 = dc0;
        load(FRAME_A5, 5'(FRAME_A5_L), 8'd2);
        chk("abort_b1", {b0, v0, d0}, 3'b110);
        step();
        abort = 1'b1;
        lv    = 1'b1;
        #1;
        chk("abort_b2", {b0, v0, d0}, 3'b010);
        chk("abort_ready_low", {r0, bz0, v0}, 3'b011);
        step();
        abort = 1'b0;
        lv    = 1'b0;
        #1;
        chk("abort_after", {b0, v0, d0}, 3'b000);
        chk("abort_ready", {r0, bz0, v0}, 3'b100);
        step(); step();
        chk("abort_stays_idle", {r0, bz0, v0}, 3'b100);
        chk("abort_no_done", 3'(dc0 - base0), 3'd0);

        // Asynchronous reset in the middle of a gap
        load(FRAME_110, 5'(FRAME_110_L), 8'd3);
        step(); step(); step();
        chk("pre_reset_gap", {r2, bz2, v2}, 3'b010);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_status2", {r2, bz2, v2}, 3'b100);
        chk("async_rst_out2", {b2, v2, d2}, 3'b000);
        chk("async_rst_status0", {r0, bz0, v0}, 3'b100);
        reset = 1'b0;
        step();

        // load_len = 0 sends all 16 bits
        e16 = 16'hA5C3;
        load(16'hA5C3, 5'd0, 8'd1);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("len0_b%0d", i), {b0, v0, d0}, {e16[15-i], 1'b1, i == 15});
            step();
        end
        chk("len0_idle", {r0, bz0, v0}, 3'b100);

        // load_len = 31 clamps to 16
        e16 = 16'h8001;
        load(16'h8001, 5'd31, 8'd1);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("len31_b%0d", i), {b2, v2, d2}, {e16[15-i], 1'b1, i == 15});
            step();
        end
        chk("len31_idle", {r2, bz2, v2}, 3'b100);

        // load_repeat = 0 sends once
        base2 = dc2;
        load(FRAME_1011, 5'(FRAME_1011_L), 8'd0);
        chk("rep0_b1", {b2, v2, d2}, 3'b110);
        step(); chk("rep0_b2", {b2, v2, d2}, 3'b010);
        step(); chk("rep0_b3", {b2, v2, d2}, 3'b110);
        step(); chk("rep0_b4", {b2, v2, d2}, 3'b111);
        step(); chk("rep0_idle", {r2, bz2, v2}, 3'b100);
        chk("rep0_done_cnt", 3'(dc2 - base2), 3'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
